lc_osc_freq_counter: RTL
========================

Name: lc_osc_freq_counter

Overview:
- Digital stage directly downstream of the voltage-controlled LC oscillator tile.
- The oscillator output is squared by a comparator and enters this block as an asynchronous digital signal.
- The block counts its rising edges over a programmable gate window of clk cycles and latches the result.
- The result is exposed byte-wise on the dedicated outputs, so frequency versus Vctrl can be read off-chip.

Parameters:
- GATE_CYCLES, 1000000: length of the gate window in clk cycles; must be ≥ 2.
- CNT_W, 24: width of the edge counter and result register, in bits; range 9..24.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  tile enable; low forces IDLE
- osc_in  in  1  squared oscillator signal, asynchronous to clk
- start  in  1  request a measurement; sampled in IDLE only
- cont_mode  in  1  1 = re-arm automatically after each LATCH
- byte_sel  in  2  readout select
- data_out  out  8  selected result byte or status byte
- busy  out  1  high in ARM, GATE and LATCH
- valid  out  1  result register holds a completed measurement
- ovf  out  1  last measurement saturated

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - Edge counter, gate counter, result, valid, ovf and synchronizer flops all = 0.
  - data_out = 0x00 (byte_sel = 0) and busy = 0.
  - Reset asserted mid-GATE discards the measurement with no partial latch.
- Input conditioning:
  - osc_in passes through a 2-flop synchronizer, then a third flop.
  - rise = s2 & ~s3, one clk pulse per rising edge.
  - Correct counts are guaranteed only for f_osc < f_clk/2; faster input aliases and this is not flagged.
- State machine (2-bit encoding):
  - IDLE -> ARM when ena & start. On accept: valid <= 0, ovf <= 0.
  - ARM, one cycle: edge counter <= 0, gate counter <= 0. Then -> GATE.
  - GATE lasts exactly GATE_CYCLES clk cycles.
    - Each cycle with rise = 1 increments the edge counter, including the first and last gate cycle.
    - The gate counter wraps to 0 at GATE_CYCLES-1, and the state moves -> LATCH.
  - LATCH, one cycle: result <= edge counter; ovf <= saturation flag; valid <= 1.
    - Then -> ARM if cont_mode, else -> IDLE.
- Latency: with start accepted at edge k, GATE spans edges k+2 .. k+1+GATE_CYCLES, and valid is high after edge k+2+GATE_CYCLES.
- start:
  - Ignored outside IDLE.
  - A held-high start in IDLE behaves like cont_mode; each accept clears valid.
- Saturation: the edge counter stops at 2^CNT_W-1 and sets an internal saturation flag, which is cleared in ARM.
- Continuous mode:
  - The result is overwritten at each LATCH.
  - valid stays 1 across re-arms; it is only cleared by a start accept from IDLE.
  - Clearing cont_mode takes effect at the next LATCH.
- ena low, any state: next state = IDLE. Counters clear; result, valid and ovf are retained.
- Readout (combinational mux off registered values):
  - byte_sel 0 -> result[7:0]
  - byte_sel 1 -> result[15:8]
  - byte_sel 2 -> result[23:16], zero-extended when CNT_W < 24
  - byte_sel 3 -> status byte {valid, ovf, busy, state[1:0], 3'b000}
- Result reads are stable while valid = 1 and the state is not LATCH.

Decomposition:
- Package lc_osc_pkg:
  - state enum: IDLE = 0, ARM = 1, GATE = 2, LATCH = 3.
  - byte_sel constants SEL_B0 .. SEL_STATUS.
  - status bit positions.
- Sub-module sync_edge_det (parameter STAGES = 2, default): async input -> synchronized level and rise pulse. Reused for the upcoming Vctrl DAC stage's pin inputs.

Test Plan:
- GATE_CYCLES = 100, osc period 10 clk, start pulse at cycle 5 -> valid high after cycle 107; bytes 0/1/2 = 0x0A/0x00/0x00; ovf = 0.
- GATE_CYCLES = 100, osc period 4 clk -> result 25; static osc_in = 1 -> result 0.
- CNT_W = 9, GATE_CYCLES = 2000, osc period 3 -> result 511 (0x1FF), ovf = 1, status byte = 0b1100_0000 in IDLE.
- cont_mode = 1, osc period 10 then switched to 5 mid-run:
  - first result 10 (GATE_CYCLES = 100);
  - a later window that lies fully after the switch reads 20;
  - busy stays 1 throughout; valid stays 1 after the first LATCH.
- rst_n pulsed low mid-GATE -> all outputs 0 immediately, state IDLE; a new start then yields a correct full-window count.
- start pulsed during GATE, and ena dropped mid-GATE:
  - start during GATE is ignored, with no extra window.
  - ena low returns to IDLE with the prior result and valid retained.

Source files
------------

// File: rtl/lc_osc_pkg.sv
`timescale 1ns/1ps
// Shared constants for the LC-oscillator frequency counter: FSM state codes,
// readout selector codes and the layout of the status byte.
package lc_osc_pkg;

  // 2-bit FSM state encoding; these codes also show up in the status byte.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_GATE  = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  // Readout selector codes.
  localparam logic [1:0] SEL_B0     = 2'd0;
  localparam logic [1:0] SEL_B1     = 2'd1;
  localparam logic [1:0] SEL_B2     = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  // Status byte bit positions. Bits [2:0] always read as zero.
  localparam int STAT_VALID    = 7;
  localparam int STAT_OVF      = 6;
  localparam int STAT_BUSY     = 5;
  localparam int STAT_STATE_HI = 4;
  localparam int STAT_STATE_LO = 3;

  // Packs the status fields into the byte returned for SEL_STATUS.
  function automatic logic [7:0] status_byte(input logic       valid,
                                             input logic       ovf,
                                             input logic       busy,
                                             input logic [1:0] state);
    logic [7:0] s;
    s                              = 8'h00;
    s[STAT_VALID]                  = valid;
    s[STAT_OVF]                    = ovf;
    s[STAT_BUSY]                   = busy;
    s[STAT_STATE_HI:STAT_STATE_LO] = state;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
`timescale 1ns/1ps
// Brings an asynchronous input into the clk domain through a STAGES-deep
// synchronizer, then one extra flop so a rising edge gives a one-cycle pulse.
module sync_edge_det #(
  parameter int STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Synchronizer shift chain plus the edge-detect delay flop.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values and the chain shifts exactly one stage per clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/lc_osc_freq_counter.sv
`timescale 1ns/1ps
// Frequency counter for the LC oscillator tile. It counts the rising edges of
// the squared oscillator over a GATE_CYCLES-long window, latches the count,
// and exposes the result and a status byte one byte at a time.
module lc_osc_freq_counter
  import lc_osc_pkg::*;
#(
  parameter int GATE_CYCLES = 1000000,  // >= 2
  parameter int CNT_W       = 24        // 9..24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       osc_in,
  input  logic       start,
  input  logic       cont_mode,
  input  logic [1:0] byte_sel,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       valid,
  output logic       ovf
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic              osc_level_unused;
  logic              osc_rise;

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic              sat_q,      sat_d;
  logic [CNT_W-1:0]  result_q,   result_d;
  logic              valid_q,    valid_d;
  logic              ovf_q,      ovf_d;
  logic [23:0]       result_ext;

  sync_edge_det #(.STAGES(2)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (osc_in),
    .level_o (osc_level_unused),
    .rise_o  (osc_rise)
  );

  // Next-state logic for the measurement FSM, counters and result registers.
  // NOTE: every target gets a hold value first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    gate_cnt_d = gate_cnt_q;
    sat_d      = sat_q;
    result_d   = result_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;

    if (!ena) begin
      // Disabled tile: abandon any window but keep the last result visible.
      state_d    = ST_IDLE;
      edge_cnt_d = '0;
      gate_cnt_d = '0;
      sat_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ARM;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        ST_ARM: begin
          edge_cnt_d = '0;
          gate_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = ST_GATE;
        end
        ST_GATE: begin
          // The flag means at least one edge arrived after the counter
          // was already full, so the stored count is a lower bound.
          if (osc_rise) begin
            if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
            else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
          if (gate_cnt_q == GATE_LAST) begin
            gate_cnt_d = '0;
            state_d    = ST_LATCH;
          end else begin
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
          end
        end
        default: begin  // ST_LATCH
          result_d = edge_cnt_q;
          ovf_d    = sat_q;
          valid_d  = 1'b1;
          state_d  = cont_mode ? ST_ARM : ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; a reset in mid-window drops the partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      edge_cnt_q <= '0;
      gate_cnt_q <= '0;
      sat_q      <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      sat_q      <= sat_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Zero-extend the result to three bytes so narrow builds read 0 in the unused upper bits.
  always_comb begin
    result_ext              = '0;
    result_ext[CNT_W-1:0]   = result_q;
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = valid_q;
  assign ovf   = ovf_q;

  // Byte-wise readout mux, driven only from registered values.
  always_comb begin
    data_out = 8'h00;
    case (byte_sel)
      SEL_B0:  data_out = result_ext[7:0];
      SEL_B1:  data_out = result_ext[15:8];
      SEL_B2:  data_out = result_ext[23:16];
      default: data_out = status_byte(valid_q, ovf_q, busy, state_q);
    endcase
  end

endmodule
